// File: rtl/service_gate_if.sv
// Bundle between the slot controller and the register-gate sequencer.
// Carries the monitor pair mrg/mwg only when SG_MONITOR_EN is defined.
interface service_gate_if #(
    parameter int NREG = 8,
    parameter int AW   = 5
);
    logic            slot_start;
    logic [NREG-1:0] rd_req;
    logic [NREG-1:0] wr_req;
    logic            rsc;
    logic            wsc;
    logic [AW-1:0]   addr;
    logic            ginh;
    logic            ci_req;
    logic [NREG-1:0] rg_n;
    logic [NREG-1:0] wg_n;
    logic [NREG-1:0] cg;
    logic            ci01_n;
    logic            busy;
    logic            overrun;
    logic            addr_err;
`ifdef SG_MONITOR_EN
    logic            mrg;
    logic            mwg;
`endif

    modport master (
        output slot_start, rd_req, wr_req, rsc, wsc, addr, ginh, ci_req,
        input  rg_n, wg_n, cg, ci01_n, busy, overrun, addr_err
`ifdef SG_MONITOR_EN
        , input mrg, mwg
`endif
    );

    modport slave (
        input  slot_start, rd_req, wr_req, rsc, wsc, addr, ginh, ci_req,
        output rg_n, wg_n, cg, ci01_n, busy, overrun, addr_err
`ifdef SG_MONITOR_EN
        , output mrg, mwg
`endif
    );
endinterface

// File: rtl/service_gate_seq.sv
// Register-gate sequencer: READ/WRITE/CLEAR/REST phases of PHW clocks each.
// Optional gate monitor outputs (mrg/mwg) are built when SG_MONITOR_EN is defined.
module service_gate_seq #(
    parameter int NREG = 8,
    parameter int AW   = 5,
    parameter int PHW  = 1
) (
    input  logic         SIM_CLK,
    input  logic         SIM_RST,
    service_gate_if.slave bus
);
    localparam int PCW = $clog2(PHW + 1);
    localparam logic [PCW-1:0] PH_LAST = PCW'(PHW - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        CLEAR = 3'd3,
        REST  = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [PCW-1:0]  ph_r;
    logic            ph_last_s;
    logic            accept_s;
    logic            ignore_s;
    logic            addr_bad_s;
    logic [NREG-1:0] r_s;
    logic [NREG-1:0] w_s;
    logic [NREG-1:0] r_r;
    logic [NREG-1:0] w_r;
    logic            ciff_r;
    logic [NREG-1:0] rg_n_s;
    logic [NREG-1:0] wg_n_s;
    logic [NREG-1:0] cg_s;
    logic            ci01_n_s;
    logic            busy_s;
    logic [NREG-1:0] rg_n_r;
    logic [NREG-1:0] wg_n_r;
    logic [NREG-1:0] cg_r;
    logic            ci01_n_r;
    logic            busy_r;
    logic            overrun_r;
    logic            addr_err_r;

    // Special-channel address decode; out-of-range addresses select nothing.
    function automatic logic [NREG-1:0] dec(input logic en, input logic [AW-1:0] a);
        logic [NREG-1:0] oh;
        if (en && (32'(a) < NREG)) begin
            oh = NREG'(1'b1) << a;
        end else begin
            oh = {NREG{1'b0}};
        end
        return oh;
    endfunction

    assign ph_last_s  = (ph_r == PH_LAST);
    assign accept_s   = bus.slot_start && ((state_r == IDLE) || ((state_r == REST) && ph_last_s));
    assign ignore_s   = bus.slot_start && !accept_s;
    assign addr_bad_s = (bus.rsc || bus.wsc) && !(32'(bus.addr) < NREG);
    assign r_s        = bus.rd_req | dec(bus.rsc, bus.addr);
    assign w_s        = (bus.wr_req | dec(bus.wsc, bus.addr)) & ~{NREG{bus.ginh}};

    // Next-state and next-output decode.
    always_comb begin
        state_s  = state_r;
        rg_n_s   = {NREG{1'b1}};
        wg_n_s   = {NREG{1'b1}};
        cg_s     = {NREG{1'b0}};
        ci01_n_s = 1'b1;
        busy_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = READ;
                end else begin
                    state_s = IDLE;
                end
            end
            READ: begin
                rg_n_s = ~r_r;
                busy_s = 1'b1;
                if (ph_last_s) begin
                    state_s = WRITE;
                end else begin
                    state_s = READ;
                end
            end
            WRITE: begin
                wg_n_s   = ~w_r;
                ci01_n_s = ~ciff_r;
                busy_s   = 1'b1;
                if (ph_last_s) begin
                    state_s = CLEAR;
                end else begin
                    state_s = WRITE;
                end
            end
            CLEAR: begin
                cg_s   = w_r;
                busy_s = 1'b1;
                if (ph_last_s) begin
                    state_s = REST;
                end else begin
                    state_s = CLEAR;
                end
            end
            REST: begin
                if (accept_s) begin
                    state_s = READ;
                end else if (ph_last_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = REST;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register and phase counter; the counter restarts on every phase change.
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            state_r <= IDLE;
            ph_r    <= {PCW{1'b0}};
        end else begin
            state_r <= state_s;
            if ((state_s != state_r) || (state_r == IDLE)) begin
                ph_r <= {PCW{1'b0}};
            end else begin
                ph_r <= ph_r + PCW'(1'b1);
            end
        end
    end

    // Slot request latches; carry-in is consumed at the end of CLEAR.
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            r_r    <= {NREG{1'b0}};
            w_r    <= {NREG{1'b0}};
            ciff_r <= 1'b0;
        end else if (accept_s) begin
            r_r    <= r_s;
            w_r    <= w_s;
            ciff_r <= bus.ci_req;
        end else if ((state_r == CLEAR) && ph_last_s) begin
            ciff_r <= 1'b0;
        end else begin
            ciff_r <= ciff_r;
        end
    end

    // Sticky error flags.
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            overrun_r  <= 1'b0;
            addr_err_r <= 1'b0;
        end else begin
            if (ignore_s) begin
                overrun_r <= 1'b1;
            end
            if (accept_s && addr_bad_s) begin
                addr_err_r <= 1'b1;
            end
        end
    end

    // Registered gate outputs, one clock behind the phase state.
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            rg_n_r   <= {NREG{1'b1}};
            wg_n_r   <= {NREG{1'b1}};
            cg_r     <= {NREG{1'b0}};
            ci01_n_r <= 1'b1;
            busy_r   <= 1'b0;
        end else begin
            rg_n_r   <= rg_n_s;
            wg_n_r   <= wg_n_s;
            cg_r     <= cg_s;
            ci01_n_r <= ci01_n_s;
            busy_r   <= busy_s;
        end
    end

    assign bus.rg_n     = rg_n_r;
    assign bus.wg_n     = wg_n_r;
    assign bus.cg       = cg_r;
    assign bus.ci01_n   = ci01_n_r;
    assign bus.busy     = busy_r;
    assign bus.overrun  = overrun_r;
    assign bus.addr_err = addr_err_r;

`ifdef SG_MONITOR_EN
    logic mrg_r;
    logic mwg_r;

    // Gate activity monitor, delayed one clock behind the gates themselves.
    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            mrg_r <= 1'b0;
            mwg_r <= 1'b0;
        end else begin
            mrg_r <= |(~rg_n_r);
            mwg_r <= |(~wg_n_r);
        end
    end

    assign bus.mrg = mrg_r;
    assign bus.mwg = mwg_r;
`endif

endmodule

// File: tb/tb_service_gate_seq.sv
// Bench for service_gate_seq: PHW=1 instance driven from a vector table,
// PHW=3 instance exercised by hand-written back-to-back, overrun and reset sequences.
module tb_service_gate_seq;
    logic clk  = 1'b0;
    logic rst1 = 1'b1;
    logic rst3 = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    service_gate_if #(.NREG(8), .AW(5)) b1 ();
    service_gate_if #(.NREG(8), .AW(5)) b3 ();

    service_gate_seq #(.NREG(8), .AW(5), .PHW(1)) u1 (.SIM_CLK(clk), .SIM_RST(rst1), .bus(b1.slave));
    service_gate_seq #(.NREG(8), .AW(5), .PHW(3)) u3 (.SIM_CLK(clk), .SIM_RST(rst3), .bus(b3.slave));

    typedef struct {
        string      name;
        logic [7:0] rd;
        logic [7:0] wr;
        logic       rsc;
        logic       wsc;
        logic [4:0] addr;
        logic       ginh;
        logic       ci;
        logic [7:0] e_rg;
        logic [7:0] e_wg;
        logic       e_ci;
        logic [7:0] e_cg;
        logic       e_aerr;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic add_vec(input string nm, input logic [7:0] rd, input logic [7:0] wr,
                           input logic rsc, input logic wsc, input logic [4:0] addr,
                           input logic ginh, input logic ci, input logic [7:0] e_rg,
                           input logic [7:0] e_wg, input logic e_ci, input logic [7:0] e_cg,
                           input logic e_aerr);
        vec_t v;
        v.name = nm; v.rd = rd; v.wr = wr; v.rsc = rsc; v.wsc = wsc; v.addr = addr;
        v.ginh = ginh; v.ci = ci; v.e_rg = e_rg; v.e_wg = e_wg; v.e_ci = e_ci;
        v.e_cg = e_cg; v.e_aerr = e_aerr;
        vq.push_back(v);
    endtask

    task automatic clear1();
        b1.slot_start = 1'b0; b1.rd_req = 8'h00; b1.wr_req = 8'h00; b1.rsc = 1'b0;
        b1.wsc = 1'b0; b1.addr = 5'd0; b1.ginh = 1'b0; b1.ci_req = 1'b0;
    endtask

    task automatic clear3();
        b3.slot_start = 1'b0; b3.rd_req = 8'h00; b3.wr_req = 8'h00; b3.rsc = 1'b0;
        b3.wsc = 1'b0; b3.addr = 5'd0; b3.ginh = 1'b0; b3.ci_req = 1'b0;
    endtask

    initial begin
        //       name     rd     wr     rsc   wsc   addr   ginh  ci    e_rg   e_wg   e_ci  e_cg   e_aerr
        add_vec("basic", 8'h05, 8'h02, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 8'hFA, 8'hFD, 1'b0, 8'h02, 1'b0);
        add_vec("rsc3",  8'h00, 8'h00, 1'b1, 1'b0, 5'd3,  1'b0, 1'b0, 8'hF7, 8'hFF, 1'b1, 8'h00, 1'b0);
        add_vec("ginh",  8'h81, 8'hFF, 1'b0, 1'b0, 5'd0,  1'b1, 1'b0, 8'h7E, 8'hFF, 1'b1, 8'h00, 1'b0);
        add_vec("wsc6",  8'h00, 8'h01, 1'b0, 1'b1, 5'd6,  1'b0, 1'b0, 8'hFF, 8'hBE, 1'b1, 8'h41, 1'b0);
        add_vec("rsc9",  8'h00, 8'h00, 1'b1, 1'b0, 5'd9,  1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b1);
        add_vec("sticky",8'h10, 8'h00, 1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 8'hEF, 8'hFF, 1'b0, 8'h00, 1'b1);

        clear1();
        clear3();
        repeat (2) @(negedge clk);
        chk("reset_u1", {b1.rg_n, b1.wg_n, b1.cg, b1.ci01_n, b1.busy, b1.overrun, b1.addr_err},
            {8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
        chk("reset_u3", {b3.rg_n, b3.wg_n, b3.cg, b3.ci01_n, b3.busy, b3.overrun, b3.addr_err},
            {8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
`ifdef SG_MONITOR_EN
        chk("reset_mon", {b1.mrg, b1.mwg}, {1'b0, 1'b0});
`endif
        rst1 = 1'b0;
        rst3 = 1'b0;

        // Table-driven single slots on the PHW=1 instance.
        foreach (vq[i]) begin
            @(negedge clk);
            b1.slot_start = 1'b1; b1.rd_req = vq[i].rd; b1.wr_req = vq[i].wr;
            b1.rsc = vq[i].rsc; b1.wsc = vq[i].wsc; b1.addr = vq[i].addr;
            b1.ginh = vq[i].ginh; b1.ci_req = vq[i].ci;
            @(negedge clk);
            clear1();
            @(negedge clk);
            chk($sformatf("%s_read", vq[i].name), {b1.rg_n, b1.wg_n, b1.cg, b1.busy},
                {vq[i].e_rg, 8'hFF, 8'h00, 1'b1});
`ifdef SG_MONITOR_EN
            chk($sformatf("%s_mon_r", vq[i].name), {b1.mrg, b1.mwg}, {1'b0, 1'b0});
`endif
            @(negedge clk);
            chk($sformatf("%s_write", vq[i].name), {b1.rg_n, b1.wg_n, b1.ci01_n, b1.cg, b1.busy},
                {8'hFF, vq[i].e_wg, vq[i].e_ci, 8'h00, 1'b1});
`ifdef SG_MONITOR_EN
            chk($sformatf("%s_mon_w", vq[i].name), {b1.mrg, b1.mwg}, {(vq[i].e_rg != 8'hFF), 1'b0});
`endif
            @(negedge clk);
            chk($sformatf("%s_clear", vq[i].name), {b1.rg_n, b1.wg_n, b1.ci01_n, b1.cg, b1.busy},
                {8'hFF, 8'hFF, 1'b1, vq[i].e_cg, 1'b1});
`ifdef SG_MONITOR_EN
            chk($sformatf("%s_mon_c", vq[i].name), {b1.mrg, b1.mwg}, {1'b0, (vq[i].e_wg != 8'hFF)});
`endif
            @(negedge clk);
            chk($sformatf("%s_rest", vq[i].name),
                {b1.rg_n, b1.wg_n, b1.ci01_n, b1.cg, b1.busy, b1.addr_err, b1.overrun},
                {8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, vq[i].e_aerr, 1'b0});
`ifdef SG_MONITOR_EN
            chk($sformatf("%s_mon_rest", vq[i].name), {b1.mrg, b1.mwg}, {1'b0, 1'b0});
`endif
            @(negedge clk);
            chk($sformatf("%s_idle", vq[i].name), {b1.rg_n, b1.wg_n, b1.cg, b1.busy},
                {8'hFF, 8'hFF, 8'h00, 1'b0});
        end

        // PHW=3: back-to-back slots, then an ignored strobe during WRITE.
        @(negedge clk);
        b3.slot_start = 1'b1; b3.rd_req = 8'h01;
        for (int j = 0; j <= 30; j++) begin
            @(negedge clk);
            if (j == 0) clear3();
            if (j == 11) begin b3.slot_start = 1'b1; b3.rd_req = 8'h02; end
            if (j == 12) clear3();
            if (j == 15) b3.slot_start = 1'b1;
            if (j == 16) clear3();
            if (j >= 1 && j <= 3)   chk($sformatf("b2b_rd1_%0d", j), {b3.rg_n, b3.busy}, {8'hFE, 1'b1});
            if (j >= 4 && j <= 9)   chk($sformatf("b2b_mid_%0d", j), {b3.rg_n, b3.busy}, {8'hFF, 1'b1});
            if (j >= 10 && j <= 12) chk($sformatf("b2b_rest_%0d", j), {b3.rg_n, b3.busy}, {8'hFF, 1'b0});
            if (j >= 13 && j <= 15) chk($sformatf("b2b_rd2_%0d", j), {b3.rg_n, b3.busy, b3.overrun},
                                        {8'hFD, 1'b1, 1'b0});
            if (j >= 18)            chk($sformatf("ovr_flag_%0d", j), b3.overrun, 1'b1);
            if (j >= 22)            chk($sformatf("ovr_nostart_%0d", j), {b3.rg_n, b3.busy}, {8'hFF, 1'b0});
        end

        // PHW=3: reset during WRITE aborts the slot and clears the flags.
        @(negedge clk);
        b3.slot_start = 1'b1; b3.wr_req = 8'h0F; b3.ci_req = 1'b1; b3.rsc = 1'b1; b3.addr = 5'd20;
        for (int j = 0; j <= 12; j++) begin
            @(negedge clk);
            if (j == 0) clear3();
            if (j == 4) begin
                chk("rst_pre_write", {b3.wg_n, b3.ci01_n, b3.addr_err, b3.overrun},
                    {8'hF0, 1'b0, 1'b1, 1'b1});
                rst3 = 1'b1;
            end
            if (j == 5) begin
                chk("rst_abort", {b3.rg_n, b3.wg_n, b3.cg, b3.ci01_n, b3.busy, b3.overrun, b3.addr_err},
                    {8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
                rst3 = 1'b0;
            end
            if (j >= 6) chk($sformatf("rst_quiet_%0d", j), {b3.wg_n, b3.cg, b3.busy}, {8'hFF, 8'h00, 1'b0});
        end
        @(negedge clk);
        b3.slot_start = 1'b1; b3.rd_req = 8'h80;
        for (int j = 0; j <= 4; j++) begin
            @(negedge clk);
            if (j == 0) clear3();
            if (j >= 1 && j <= 3) chk($sformatf("post_rst_rd_%0d", j), {b3.rg_n, b3.busy}, {8'h7F, 1'b1});
            if (j == 4) chk("post_rst_wr", b3.rg_n, 8'hFF);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
